// File: rtl/w5500_pkg.sv
// Shared definitions for the W5500 SPI arbiter: FSM encoding, control-byte fields, defaults.
package w5500_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } arb_state_e;

    // W5500 control byte: [7:3] block select, [2] RWB, [1:0] operation mode
    localparam int unsigned CTRL_BSB_LSB   = 3;
    localparam int unsigned CTRL_BSB_W     = 5;
    localparam int unsigned CTRL_RWB_BIT   = 2;
    localparam logic        CTRL_RWB_WRITE = 1'b1;
    localparam logic [1:0]  CTRL_OM_VDM    = 2'b00;

    // Watchdog budget from engine start to spi_wr_end
    localparam logic [19:0] TMO_CYC_DEF = 20'd1000000;

    // Build a variable-length-data-mode control byte
    function automatic logic [7:0] w5500_ctrl(input logic [4:0] bsb, input logic rwb);
        logic [7:0] ctrl;
        ctrl                                = '0;
        ctrl[CTRL_BSB_LSB +: CTRL_BSB_W]    = bsb;
        ctrl[CTRL_RWB_BIT]                  = rwb;
        ctrl[1:0]                           = CTRL_OM_VDM;
        return ctrl;
    endfunction

endpackage

// File: rtl/spi_arb_rr_pick.sv
// Combinational round-robin selector: first requester at or after the pointer, wrapping.
module rr_pick #(
    parameter int unsigned N_REQ = 3,
    parameter int unsigned IW    = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IW-1:0]    ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IW-1:0]    idx_o
);

    logic [N_REQ-1:0] rot;
    logic [IW-1:0]    off;
    logic [IW:0]      sum;
    logic             found;

    // Rotate the pointer to bit 0, take the first set bit, then undo the rotation
    always_comb begin
        rot   = N_REQ'({req_i, req_i} >> ptr_i);
        found = 1'b0;
        off   = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                off   = IW'(k);
            end
        end
        sum = {1'b0, ptr_i} + {1'b0, off};
        if (sum >= (IW+1)'(N_REQ)) begin
            sum = sum - (IW+1)'(N_REQ);
        end
        idx_o = sum[IW-1:0];
        gnt_o = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            gnt_o[i] = found && (sum == (IW+1)'(i));
        end
    end

endmodule

// File: rtl/spi_arb.sv
// Round-robin arbiter sharing one spi_drv engine among N_REQ requesters.
module spi_arb
    import w5500_pkg::*;
#(
    parameter int unsigned      N_REQ   = 3,
    parameter int unsigned      TMO_W   = 20,
    parameter logic [TMO_W-1:0] TMO_CYC = TMO_W'(TMO_CYC_DEF)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req,
    input  logic [8*N_REQ-1:0]    req_cmd,
    input  logic [16*N_REQ-1:0]   req_addr,
    input  logic [16*N_REQ-1:0]   req_len,
    input  logic [8*N_REQ-1:0]    req_dat,
    output logic [N_REQ-1:0]      o_gnt,
    output logic [N_REQ-1:0]      o_rdreq,
    output logic [N_REQ-1:0]      o_rd_vld,
    output logic [7:0]            o_rd_dat,
    output logic [N_REQ-1:0]      o_done,
    output logic [N_REQ-1:0]      o_err,
    output logic                  o_spi_start,
    output logic [7:0]            o_spi_cmd,
    output logic [15:0]           o_spi_addr,
    output logic [15:0]           o_spi_len,
    output logic [7:0]            o_spi_dat,
    input  logic                  spi_dat_req,
    input  logic                  spi_dat_vld,
    input  logic [7:0]            spi_dat,
    input  logic                  spi_wr_end
);

    localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_e        state_q, state_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [IW-1:0]     gidx_q, gidx_d;
    logic [IW-1:0]     rr_q, rr_d;
    logic [TMO_W-1:0]  wdog_q, wdog_d;
    logic [7:0]        cmd_q, cmd_d;
    logic [15:0]       addr_q, addr_d;
    logic [15:0]       len_q, len_d;
    logic              start_q, start_d;
    logic [N_REQ-1:0]  done_q, done_d;
    logic [N_REQ-1:0]  err_q, err_d;

    logic [N_REQ-1:0]  pick_gnt;
    logic [IW-1:0]     pick_idx;
    logic [7:0]        sel_cmd;
    logic [15:0]       sel_addr;
    logic [15:0]       sel_len;
    logic [7:0]        sel_dat;
    logic              run;

    rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_pick (
        .req_i (req),
        .ptr_i (rr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx)
    );

    // Command fields of the arbitration winner
    always_comb begin
        sel_cmd  = '0;
        sel_addr = '0;
        sel_len  = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (pick_gnt[i]) begin
                sel_cmd  = req_cmd[8*i +: 8];
                sel_addr = req_addr[16*i +: 16];
                sel_len  = req_len[16*i +: 16];
            end
        end
    end

    // Write byte of the current grant holder
    always_comb begin
        sel_dat = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (gnt_q[i]) begin
                sel_dat = req_dat[8*i +: 8];
            end
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        gidx_d  = gidx_q;
        rr_d    = rr_q;
        wdog_d  = wdog_q;
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        len_d   = len_q;
        start_d = 1'b0;
        done_d  = '0;
        err_d   = '0;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    gnt_d   = pick_gnt;
                    gidx_d  = pick_idx;
                    cmd_d   = sel_cmd;
                    addr_d  = sel_addr;
                    len_d   = sel_len;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (len_q == 16'd0) begin
                    done_d  = gnt_q;
                    err_d   = gnt_q;
                    state_d = ST_DONE;
                end else begin
                    start_d = 1'b1;
                    wdog_d  = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                wdog_d = wdog_q + TMO_W'(1);
                // A real end strobe wins over a watchdog expiry in the same cycle
                if (spi_wr_end) begin
                    done_d  = gnt_q;
                    state_d = ST_DONE;
                end else if (wdog_q == TMO_CYC - TMO_W'(1)) begin
                    done_d  = gnt_q;
                    err_d   = gnt_q;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                gnt_d   = '0;
                rr_d    = (gidx_q == IW'(N_REQ - 1)) ? '0 : gidx_q + IW'(1);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            gidx_q  <= '0;
            rr_q    <= '0;
            wdog_q  <= '0;
            cmd_q   <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            start_q <= 1'b0;
            done_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            gidx_q  <= gidx_d;
            rr_q    <= rr_d;
            wdog_q  <= wdog_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            start_q <= start_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Engine strobes reach only the grant holder, and only while the engine runs
    assign run         = (state_q == ST_RUN);
    assign o_rdreq     = run ? (gnt_q & {N_REQ{spi_dat_req}}) : '0;
    assign o_rd_vld    = run ? (gnt_q & {N_REQ{spi_dat_vld}}) : '0;
    assign o_rd_dat    = run ? spi_dat : '0;
    assign o_spi_dat   = run ? sel_dat : '0;
    assign o_gnt       = gnt_q;
    assign o_done      = done_q;
    assign o_err       = err_q;
    assign o_spi_start = start_q;
    assign o_spi_cmd   = cmd_q;
    assign o_spi_addr  = addr_q;
    assign o_spi_len   = len_q;

endmodule

// File: tb/tb_spi_arb.sv
// Self-checking bench for spi_arb: directed scenarios plus randomized transactions.
module tb_spi_arb;
    import w5500_pkg::*;

    localparam int unsigned N   = 3;
    localparam int unsigned TMO = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req;
    logic [8*N-1:0]    req_cmd;
    logic [16*N-1:0]   req_addr;
    logic [16*N-1:0]   req_len;
    logic [8*N-1:0]    req_dat;
    logic [N-1:0]      o_gnt, o_rdreq, o_rd_vld, o_done, o_err;
    logic [7:0]        o_rd_dat, o_spi_cmd, o_spi_dat;
    logic [15:0]       o_spi_addr, o_spi_len;
    logic              o_spi_start;
    logic              spi_dat_req, spi_dat_vld, spi_wr_end;
    logic [7:0]        spi_dat;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int rr_m  = 0;
    int last_done_cyc = -1;
    logic [7:0] wq[$];
    logic [7:0] rdq[$];

    spi_arb #(.N_REQ(N), .TMO_W(20), .TMO_CYC(20'(TMO))) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .req_cmd     (req_cmd),
        .req_addr    (req_addr),
        .req_len     (req_len),
        .req_dat     (req_dat),
        .o_gnt       (o_gnt),
        .o_rdreq     (o_rdreq),
        .o_rd_vld    (o_rd_vld),
        .o_rd_dat    (o_rd_dat),
        .o_done      (o_done),
        .o_err       (o_err),
        .o_spi_start (o_spi_start),
        .o_spi_cmd   (o_spi_cmd),
        .o_spi_addr  (o_spi_addr),
        .o_spi_len   (o_spi_len),
        .o_spi_dat   (o_spi_dat),
        .spi_dat_req (spi_dat_req),
        .spi_dat_vld (spi_dat_vld),
        .spi_dat     (spi_dat),
        .spi_wr_end  (spi_wr_end)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL bench_timeout observed=running expected=finished");
        $fatal(1, "bench time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [N-1:0] oh(input int i);
        return N'(1) << i;
    endfunction

    function automatic logic [7:0] sl8(input logic [8*N-1:0] v, input int i);
        logic [8*N-1:0] t;
        t = v >> (8*i);
        return t[7:0];
    endfunction

    function automatic logic [15:0] sl16(input logic [16*N-1:0] v, input int i);
        logic [16*N-1:0] t;
        t = v >> (16*i);
        return t[15:0];
    endfunction

    // Reference arbitration: first requester scanning upward from the pointer, modulo N
    function automatic int model_pick(input logic [N-1:0] r, input int ptr);
        logic [N-1:0] sh;
        for (int k = 0; k < int'(N); k++) begin
            sh = r >> ((ptr + k) % int'(N));
            if (sh[0]) return (ptr + k) % int'(N);
        end
        return -1;
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_gnt"},   32'(o_gnt),       32'd0);
        chk({tag, "_start"}, 32'(o_spi_start), 32'd0);
        chk({tag, "_done"},  32'(o_done),      32'd0);
        chk({tag, "_err"},   32'(o_err),       32'd0);
        chk({tag, "_rdreq"}, 32'(o_rdreq),     32'd0);
        chk({tag, "_rdvld"}, 32'(o_rd_vld),    32'd0);
        chk({tag, "_rddat"}, 32'(o_rd_dat),    32'd0);
        chk({tag, "_cmd"},   32'(o_spi_cmd),   32'd0);
        chk({tag, "_addr"},  32'(o_spi_addr),  32'd0);
        chk({tag, "_len"},   32'(o_spi_len),   32'd0);
        chk({tag, "_wdat"},  32'(o_spi_dat),   32'd0);
    endtask

    // One transaction for winner g; called in an IDLE cycle with req already driven.
    // end_mode: 0 = spi_wr_end, 1 = watchdog expiry, 2 = spi_wr_end on the expiry cycle
    task automatic xfer(input int g, input int nbytes, input int end_mode);
        logic [7:0]  e_cmd, wb;
        logic [15:0] e_addr, e_len;
        logic        rq, vl, exp_err;
        int          s_cyc;
        e_cmd  = sl8(req_cmd, g);
        e_addr = sl16(req_addr, g);
        e_len  = sl16(req_len, g);
        exp_err = 1'b0;
        tick();
        chk("load_gnt",  32'(o_gnt),       32'(oh(g)));
        chk("load_cmd",  32'(o_spi_cmd),   32'(e_cmd));
        chk("load_addr", 32'(o_spi_addr),  32'(e_addr));
        chk("load_len",  32'(o_spi_len),   32'(e_len));
        chk("load_nostart", 32'(o_spi_start), 32'd0);
        if (last_done_cyc >= 0) chk("grant_gap", 32'(cyc - last_done_cyc), 32'd2);
        req_cmd  = (8*N)'({$urandom, $urandom});
        req_addr = (16*N)'({$urandom, $urandom});
        req_len  = (16*N)'({$urandom, $urandom});
        tick();
        if (e_len == 16'd0) begin
            chk("zl_nostart", 32'(o_spi_start), 32'd0);
            exp_err = 1'b1;
        end else begin
            chk("start", 32'(o_spi_start), 32'd1);
            chk("run_cmd_held", 32'(o_spi_cmd), 32'(e_cmd));
            s_cyc = cyc;
            for (int i = 0; i < nbytes; i++) begin
                rq = 1'($urandom);
                vl = 1'($urandom);
                spi_dat = 8'($urandom);
                req_dat = (8*N)'({$urandom, $urandom});
                if (wq.size() > 0) begin
                    rq = 1'b1;
                    wb = wq.pop_front();
                    req_dat = (req_dat & ~((8*N)'(8'hFF) << (8*g))) | ((8*N)'(wb) << (8*g));
                end
                if (rdq.size() > 0) begin
                    vl = 1'b1;
                    spi_dat = rdq.pop_front();
                end
                spi_dat_req = rq;
                spi_dat_vld = vl;
                #1;
                chk("rdreq",  32'(o_rdreq),   32'(rq ? oh(g) : '0));
                chk("wdat",   32'(o_spi_dat), 32'(sl8(req_dat, g)));
                chk("rd_vld", 32'(o_rd_vld),  32'(vl ? oh(g) : '0));
                chk("rd_dat", 32'(o_rd_dat),  32'(spi_dat));
                tick();
                spi_dat_req = 1'b0;
                spi_dat_vld = 1'b0;
                if (i == 0) chk("start_pulse", 32'(o_spi_start), 32'd0);
            end
            case (end_mode)
                1: begin
                    while (cyc - s_cyc < int'(TMO)) begin
                        chk("tmo_early_done", 32'(o_done), 32'd0);
                        tick();
                    end
                    exp_err = 1'b1;
                end
                2: begin
                    while (cyc - s_cyc < int'(TMO) - 1) tick();
                    spi_wr_end = 1'b1;
                    tick();
                    spi_wr_end = 1'b0;
                end
                default: begin
                    spi_wr_end = 1'b1;
                    tick();
                    spi_wr_end = 1'b0;
                end
            endcase
        end
        chk("done", 32'(o_done), 32'(oh(g)));
        chk("err",  32'(o_err),  32'(exp_err ? oh(g) : '0));
        last_done_cyc = cyc;
        rr_m = (g + 1) % int'(N);
        tick();
        chk("done_clr", 32'(o_done), 32'd0);
        chk("gnt_clr",  32'(o_gnt),  32'd0);
    endtask

    initial begin
        int g;
        int nb;
        int md;
        rst_n = 1'b1;
        req = '0; req_cmd = '0; req_addr = '0; req_len = '0; req_dat = '0;
        spi_dat_req = 1'b0; spi_dat_vld = 1'b0; spi_wr_end = 1'b0; spi_dat = '0;

        // Reset state, with strobes and requests active to show they are masked
        #3 rst_n = 1'b0;
        req = '1; spi_dat_req = 1'b1; spi_dat_vld = 1'b1; spi_wr_end = 1'b1; spi_dat = 8'hA5;
        #1 chk_zero("reset");
        tick();
        tick();
        chk("reset_held_gnt", 32'(o_gnt), 32'd0);
        req = '0; spi_dat_req = 1'b0; spi_dat_vld = 1'b0; spi_wr_end = 1'b0; spi_dat = '0;
        #2 rst_n = 1'b1;
        tick();

        // Round robin with all requesters held: expected order 0,1,2,0
        req_cmd  = {8'h0C, 8'h08, 8'h04};
        req_addr = {16'h0300, 16'h0200, 16'h0100};
        req_len  = {16'd3, 16'd2, 16'd1};
        req = '1;
        for (int k = 0; k < 4; k++) begin
            g = model_pick(req, rr_m);
            xfer(g, 1, 0);
            req_len = {16'd3, 16'd2, 16'd1};
        end
        req = '0;

        // Single write from requester 0, write byte 8'h80
        req_cmd  = (8*N)'(w5500_ctrl(5'd0, CTRL_RWB_WRITE));
        req_addr = '0;
        req_len  = (16*N)'(16'd1);
        req = 3'b001;
        wq.push_back(8'h80);
        xfer(model_pick(req, rr_m), 1, 0);

        // Zero length on requester 1
        req_len = {16'd5, 16'd0, 16'd5};
        req = 3'b010;
        xfer(model_pick(req, rr_m), 0, 0);

        // Read routing on requester 2
        req_len = {16'd4, 16'd1, 16'd1};
        req = 3'b100;
        rdq.push_back(8'h11); rdq.push_back(8'h22); rdq.push_back(8'h33); rdq.push_back(8'h44);
        xfer(model_pick(req, rr_m), 4, 0);

        // Watchdog expiry, then end strobe coinciding with expiry
        req_len = {16'd7, 16'd7, 16'd7};
        req = 3'b001;
        xfer(model_pick(req, rr_m), 2, 1);
        req_len = {16'd7, 16'd7, 16'd7};
        req = 3'b010;
        xfer(model_pick(req, rr_m), 0, 2);
        req = '0;

        // Stray engine strobes while idle
        spi_dat_req = 1'b1; spi_dat_vld = 1'b1; spi_wr_end = 1'b1; spi_dat = 8'h5A;
        #1;
        chk("stray_rdreq", 32'(o_rdreq),  32'd0);
        chk("stray_rdvld", 32'(o_rd_vld), 32'd0);
        tick();
        chk("stray_done",  32'(o_done),      32'd0);
        chk("stray_start", 32'(o_spi_start), 32'd0);
        tick();
        chk("stray_gnt",   32'(o_gnt),       32'd0);
        spi_dat_req = 1'b0; spi_dat_vld = 1'b0; spi_wr_end = 1'b0;
        last_done_cyc = -1;

        // Randomized transactions against the reference arbitration model
        for (int it = 0; it < 12; it++) begin
            req      = N'($urandom_range(1, (1 << N) - 1));
            req_cmd  = (8*N)'({$urandom, $urandom});
            req_addr = (16*N)'({$urandom, $urandom});
            req_len  = (16*N)'({$urandom, $urandom}) | (16*N)'(48'h0001_0001_0001);
            g = model_pick(req, rr_m);
            if ($urandom_range(0, 3) == 0) begin
                req_len = req_len & ~((16*N)'(16'hFFFF) << (16*g));
            end
            nb = int'($urandom_range(0, 6));
            md = int'($urandom_range(0, 2));
            xfer(g, nb, md);
        end
        req = '0;

        // Reset while the engine runs: everything drops, no completion afterwards
        req_len = {16'd9, 16'd9, 16'd9};
        req = 3'b100;
        g = model_pick(req, rr_m);
        tick();
        tick();
        chk("rst_run_start", 32'(o_spi_start), 32'd1);
        spi_dat_req = 1'b1; spi_dat_vld = 1'b1; spi_dat = 8'h3C;
        #1 chk("rst_run_rdreq", 32'(o_rdreq), 32'(oh(g)));
        #1 rst_n = 1'b0;
        #1 chk_zero("rst_run");
        req = '0; spi_dat_req = 1'b0; spi_dat_vld = 1'b0; spi_dat = '0;
        #2 rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("post_rst_done", 32'(o_done), 32'd0);
            chk("post_rst_gnt",  32'(o_gnt),  32'd0);
        end
        rr_m = 0;
        last_done_cyc = -1;
        req_len = {16'd1, 16'd1, 16'd1};
        req = '1;
        xfer(model_pick(req, rr_m), 1, 0);
        req = '0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
